// File: rtl/vga_framebuffer_reader.sv
// VGA 640x480@60 timing generator that scans the frame-buffer read port in raster order
// and realigns syncs/flags with the BRAM read latency so all pins change together.
module vga_framebuffer_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int RD_LAT   = 1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PIPE    = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]   PIX_LAST   = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic          SYNC_ON    = (SYNC_POL != 0);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic [18:0]     pix_cnt;
  logic            running;
  logic            line_end;
  logic            frame_end;
  logic            active0;
  logic            hs0;
  logic            vs0;
  logic            first0;
  logic [PIPE-1:0] act_pipe;
  logic [PIPE-1:0] hs_pipe;
  logic [PIPE-1:0] vs_pipe;
  logic [PIPE-1:0] first_pipe;

  assign running   = (state_q == RUN);
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // en is only honoured on the last cycle of a frame so a frame is never cut short
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!running) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign active0 = running && (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs0     = running && (hcnt >= HS_BEGIN) && (hcnt < HS_END);
  assign vs0     = running && (vcnt >= VS_BEGIN) && (vcnt < VS_END);
  assign first0  = active0 && (hcnt == '0) && (vcnt == '0);

  // Linear pixel counter never resets per line; it saturates so the address stays in range
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= active0;
      if (!running) begin
        rd_addr <= '0;
      end else if (active0) begin
        rd_addr <= pix_cnt;
      end
      if (!running || frame_end) begin
        pix_cnt <= '0;
      end else if (active0 && (pix_cnt != PIX_LAST)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      act_pipe   <= '0;
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      first_pipe <= '0;
    end else begin
      act_pipe   <= {act_pipe[PIPE-2:0], active0};
      hs_pipe    <= {hs_pipe[PIPE-2:0], hs0};
      vs_pipe    <= {vs_pipe[PIPE-2:0], vs0};
      first_pipe <= {first_pipe[PIPE-2:0], first0};
    end
  end

  // Last pipe stage lines up with rd_data; this register is the common output stage
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_ON;
      vga_vs      <= ~SYNC_ON;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= hs_pipe[PIPE-1] ? SYNC_ON : ~SYNC_ON;
      vga_vs      <= vs_pipe[PIPE-1] ? SYNC_ON : ~SYNC_ON;
      frame_start <= first_pipe[PIPE-1];
      if (act_pipe[PIPE-1]) begin
        {vga_r, vga_g, vga_b} <= rd_data;
      end else begin
        {vga_r, vga_g, vga_b} <= '0;
      end
    end
  end

endmodule
